// File: rtl/cache_requester.sv
// cache_requester: single-outstanding requester in front of a duplicated SRAM pair.
// Each read samples both copies and flags any difference. A flagged difference
// bumps a saturating error counter.
//
// Optional feature: define CACHE_REQUESTER_SCRUB_EN to rewrite copy-1 data to
// the address after a mismatched read. This write happens before the response.
//
// Ports:
//   Clk_CI, Rst_RI               clock, synchronous active-high reset
//   ReqValid_SI/ReqReady_SO      request handshake
//   ReqWrEn_SI, ReqBEn_SI,
//   ReqAddr_DI, ReqWrData_DI     request fields (latched on acceptance)
//   RspValid_SO/RspReady_SI      response handshake
//   RspData_DO, RspErr_SO        read data (copy 1), copy-mismatch flag
//   ErrCnt_DO                    saturating mismatch count
//   CSel_SO, WrEn_SO, BEn_SO,
//   WrData_DO, Addr_DO           command to both SRAM copies
//   RdData_DI_1, RdData_DI_2     read data from copy 1 / copy 2
module cache_requester #(
  parameter int ADDR_WIDTH = 7,
  parameter int OUT_REGS   = 0
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrEn_SI,
  input  logic [7:0]            ReqBEn_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [63:0]           ReqWrData_DI,
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [63:0]           RspData_DO,
  output logic                  RspErr_SO,
  output logic [15:0]           ErrCnt_DO,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [7:0]            BEn_SO,
  output logic [63:0]           WrData_DO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  input  logic [63:0]           RdData_DI_1,
  input  logic [63:0]           RdData_DI_2
);

  localparam int CNT_W = (OUT_REGS > 0) ? $clog2(OUT_REGS + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCRUB, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    wr_en_q, wr_en_d;
  logic [7:0]              ben_q, ben_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [63:0]             wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [63:0]             rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic                    mismatch;

  assign mismatch    = (RdData_DI_1 != RdData_DI_2);
  assign RspData_DO  = rsp_data_q;
  assign RspErr_SO   = rsp_err_q;
  assign ErrCnt_DO   = err_cnt_q;

  always_comb begin
    state_d    = state_q;
    wr_en_d    = wr_en_q;
    ben_d      = ben_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    err_cnt_d  = err_cnt_q;
    ReqReady_SO = 1'b0;
    RspValid_SO = 1'b0;
    CSel_SO     = 1'b0;
    WrEn_SO     = 1'b0;
    BEn_SO      = '0;
    WrData_DO   = '0;
    Addr_DO     = '0;

    case (state_q)
      IDLE: begin
        ReqReady_SO = 1'b1;
        if (ReqValid_SI) begin
          wr_en_d = ReqWrEn_SI;
          ben_d   = ReqBEn_SI;
          addr_d  = ReqAddr_DI;
          wdata_d = ReqWrData_DI;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        CSel_SO   = 1'b1;
        WrEn_SO   = wr_en_q;
        BEn_SO    = ben_q;
        WrData_DO = wdata_q;
        Addr_DO   = addr_q;
        cnt_d     = '0;
        if (wr_en_q) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Last WAIT cycle is the one where SRAM read data is valid.
        if (cnt_q == CNT_W'(OUT_REGS)) begin
          rsp_data_d = RdData_DI_1;
          rsp_err_d  = mismatch;
          if (mismatch && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
          state_d = RESP;
`ifdef CACHE_REQUESTER_SCRUB_EN
          if (mismatch) state_d = SCRUB;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCRUB: begin
`ifdef CACHE_REQUESTER_SCRUB_EN
        // Rewrite both copies with copy-1 data captured at the sample.
        CSel_SO   = 1'b1;
        WrEn_SO   = 1'b1;
        BEn_SO    = 8'hFF;
        WrData_DO = rsp_data_q;
        Addr_DO   = addr_q;
        state_d   = RESP;
`else
        state_d   = IDLE;
`endif
      end
      RESP: begin
        RspValid_SO = 1'b1;
        if (RspReady_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      ben_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      ben_q      <= ben_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester. It runs two instances side by side with
// OUT_REGS=0 and OUT_REGS=1. Both share the request bus. Each has its own
// SRAM-pair model. That model drives garbage on RdData except in the cycle
// where read data is valid.
module tb_cache_requester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [7:0]  req_ben = '0;
  logic [6:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;

  logic        req_ready[2], rsp_valid[2], rsp_ready[2], rsp_err[2], csel[2], wren[2];
  logic [7:0]  ben[2];
  logic [6:0]  addr[2];
  logic [63:0] rsp_data[2], wdata[2], rd1[2], rd2[2];
  logic [15:0] err_cnt[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_requester #(.ADDR_WIDTH(7), .OUT_REGS(g)) u_dut (
      .Clk_CI(clk), .Rst_RI(rst),
      .ReqValid_SI(req_valid), .ReqReady_SO(req_ready[g]),
      .ReqWrEn_SI(req_wr), .ReqBEn_SI(req_ben), .ReqAddr_DI(req_addr), .ReqWrData_DI(req_wdata),
      .RspValid_SO(rsp_valid[g]), .RspReady_SI(rsp_ready[g]),
      .RspData_DO(rsp_data[g]), .RspErr_SO(rsp_err[g]), .ErrCnt_DO(err_cnt[g]),
      .CSel_SO(csel[g]), .WrEn_SO(wren[g]), .BEn_SO(ben[g]), .WrData_DO(wdata[g]), .Addr_DO(addr[g]),
      .RdData_DI_1(rd1[g]), .RdData_DI_2(rd2[g])
    );
  end

  int          tests = 0, fails = 0;
  logic [15:0] exp_cnt = '0;
  bit          mon_en = 1'b0;
  logic [64:0] sb0[$], sb1[$];
  logic [63:0] m1[128], m2[128];

  // SRAM-pair models: 1 and 2 cycles of read latency.
  logic        v0, v1a, v1b;
  logic [6:0]  a1;
  logic [63:0] d0a, d0b, d1a, d1b;
  always @(posedge clk) begin
    v0  <= csel[0] && !wren[0];
    d0a <= m1[addr[0]];
    d0b <= m2[addr[0]];
    v1a <= csel[1] && !wren[1];
    a1  <= addr[1];
    v1b <= v1a;
    d1a <= m1[a1];
    d1b <= m2[a1];
  end
  always_comb begin
    rd1[0] = v0  ? d0a : 64'hBAD0_0000_0000_0001;
    rd2[0] = v0  ? d0b : 64'hBAD0_0000_0000_0002;
    rd1[1] = v1b ? d1a : 64'hBAD1_0000_0000_0001;
    rd2[1] = v1b ? d1b : 64'hBAD1_0000_0000_0002;
  end

  // SRAM command monitor: counts chip selects and keeps the last command seen.
  int          csel_cnt[2];
  logic        w_wr[2];
  logic [7:0]  w_ben[2];
  logic [6:0]  w_addr[2];
  logic [63:0] w_data[2];
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (csel[d]) begin
          csel_cnt[d]++;
          w_wr[d] = wren[d]; w_ben[d] = ben[d]; w_addr[d] = addr[d]; w_data[d] = wdata[d];
          if (rsp_valid[d] !== 1'b0) begin
            fails++;
            $display("FAIL csel_during_rsp dut%0d: rsp_valid=%b, want 0", d, rsp_valid[d]);
          end
        end else if ({wren[d], ben[d], wdata[d], addr[d]} !== '0) begin
          fails++;
          $display("FAIL sram_idle dut%0d: wren=%b ben=%h wdata=%h addr=%h, want all 0",
                   d, wren[d], ben[d], wdata[d], addr[d]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one request to both instances and queue the expected response.
  task automatic issue(input bit wr, input logic [7:0] be, input logic [6:0] a,
                       input logic [63:0] wd, input logic [63:0] ed, input bit ee);
    int n = 0;
    while (!(req_ready[0] === 1'b1 && req_ready[1] === 1'b1) && n < 50) begin tick; n++; end
    req_valid = 1'b1; req_wr = wr; req_ben = be; req_addr = a; req_wdata = wd;
    tick;
    // Scramble fields: they must not matter after acceptance.
    req_valid = 1'b0; req_wr = ~wr; req_ben = ~be; req_addr = ~a; req_wdata = ~wd;
    sb0.push_back({ee, ed});
    sb1.push_back({ee, ed});
    tests++;
    if (csel[0] !== 1'b1 || csel[1] !== 1'b1) begin
      fails++;
      $display("FAIL issue_csel: csel=%b/%b, want 1/1", csel[0], csel[1]);
    end
  endtask

  task automatic collect(input int d);
    logic [64:0] exp;
    int n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin tick; n++; end
    exp = 'x;
    if (d == 0 && sb0.size() > 0) exp = sb0.pop_front();
    if (d == 1 && sb1.size() > 0) exp = sb1.pop_front();
    tests++;
    if (rsp_valid[d] !== 1'b1) begin
      fails++;
      $display("FAIL rsp_timeout dut%0d: no rsp_valid within 40 cycles", d);
    end else if ({rsp_err[d], rsp_data[d]} !== exp) begin
      fails++;
      $display("FAIL rsp dut%0d: err=%b data=%h, want err=%b data=%h",
               d, rsp_err[d], rsp_data[d], exp[64], exp[63:0]);
    end
    rsp_ready[d] = 1'b1;
    tick;
    rsp_ready[d] = 1'b0;
    tests++;
    if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
      fails++;
      $display("FAIL after_handshake dut%0d: req_ready=%b rsp_valid=%b, want 1/0",
               d, req_ready[d], rsp_valid[d]);
    end
  endtask

  task automatic test_reset;
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    mon_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({req_ready[d], rsp_valid[d], rsp_data[d], rsp_err[d], err_cnt[d], csel[d]} !==
          {1'b1, 1'b0, 64'h0, 1'b0, 16'h0, 1'b0}) begin
        fails++;
        $display("FAIL reset dut%0d: ready=%b vld=%b data=%h err=%b cnt=%h csel=%b",
                 d, req_ready[d], rsp_valid[d], rsp_data[d], rsp_err[d], err_cnt[d], csel[d]);
      end
    end
  endtask

  task automatic test_write;
    int b[2];
    b[0] = csel_cnt[0]; b[1] = csel_cnt[1];
    issue(1'b1, 8'h0F, 7'h05, 64'h1122334455667788, 64'h0, 1'b0);
    collect(0); collect(1);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (csel_cnt[d] != b[d] + 1 || {w_wr[d], w_ben[d], w_addr[d], w_data[d]} !==
          {1'b1, 8'h0F, 7'h05, 64'h1122334455667788}) begin
        fails++;
        $display("FAIL write_cmd dut%0d: csels=%0d wr=%b ben=%h addr=%h data=%h, want 1 1 0f 05 1122334455667788",
                 d, csel_cnt[d] - b[d], w_wr[d], w_ben[d], w_addr[d], w_data[d]);
      end
      tests++;
      if (err_cnt[d] !== exp_cnt) begin
        fails++; $display("FAIL write_errcnt dut%0d: %h, want %h", d, err_cnt[d], exp_cnt);
      end
    end
  endtask

  task automatic test_read;
    int b[2];
    b[0] = csel_cnt[0]; b[1] = csel_cnt[1];
    issue(1'b0, 8'h00, 7'h05, 64'h0, 64'hA5A5, 1'b0);
    collect(0); collect(1);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (csel_cnt[d] != b[d] + 1 || w_wr[d] !== 1'b0 || w_addr[d] !== 7'h05 || err_cnt[d] !== exp_cnt) begin
        fails++;
        $display("FAIL read_cmd dut%0d: csels=%0d wr=%b addr=%h cnt=%h, want 1 0 05 %h",
                 d, csel_cnt[d] - b[d], w_wr[d], w_addr[d], err_cnt[d], exp_cnt);
      end
    end
  endtask

  task automatic test_mismatch;
    int b[2];
    int exp_csels;
    b[0] = csel_cnt[0]; b[1] = csel_cnt[1];
    issue(1'b0, 8'h00, 7'h09, 64'h0, 64'h1, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
    collect(0); collect(1);
`ifdef CACHE_REQUESTER_SCRUB_EN
    exp_csels = 2;
`else
    exp_csels = 1;
`endif
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (err_cnt[d] !== exp_cnt) begin
        fails++; $display("FAIL mismatch_errcnt dut%0d: %h, want %h", d, err_cnt[d], exp_cnt);
      end
      tests++;
      if (csel_cnt[d] != b[d] + exp_csels) begin
        fails++;
        $display("FAIL mismatch_csels dut%0d: %0d, want %0d", d, csel_cnt[d] - b[d], exp_csels);
      end
`ifdef CACHE_REQUESTER_SCRUB_EN
      tests++;
      if ({w_wr[d], w_ben[d], w_addr[d], w_data[d]} !== {1'b1, 8'hFF, 7'h09, 64'h1}) begin
        fails++;
        $display("FAIL scrub_cmd dut%0d: wr=%b ben=%h addr=%h data=%h, want 1 ff 09 1",
                 d, w_wr[d], w_ben[d], w_addr[d], w_data[d]);
      end
`else
      tests++;
      if (w_wr[d] !== 1'b0) begin
        fails++; $display("FAIL no_scrub dut%0d: last wren=%b, want 0", d, w_wr[d]);
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    int b[2];
    int n = 0;
    issue(1'b0, 8'h00, 7'h05, 64'h0, 64'hA5A5, 1'b0);
    while (rsp_valid[0] !== 1'b1 && n < 40) begin tick; n++; end
    b[0] = csel_cnt[0]; b[1] = csel_cnt[1];
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 64'hA5A5 || req_ready[0] !== 1'b0) begin
        fails++;
        $display("FAIL hold cycle%0d: vld=%b data=%h ready=%b, want 1 a5a5 0",
                 i, rsp_valid[0], rsp_data[0], req_ready[0]);
      end
      tick;
    end
    tests++;
    if (csel_cnt[0] != b[0] || csel_cnt[1] != b[1]) begin
      fails++;
      $display("FAIL hold_csel: extra csels %0d/%0d, want 0/0", csel_cnt[0] - b[0], csel_cnt[1] - b[1]);
    end
    collect(0); collect(1);
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 8'h00, 7'h0C, 64'h0, 64'hCAFEF00D12345678, 1'b0);
    collect(0); collect(1);
    issue(1'b0, 8'h00, 7'h05, 64'h0, 64'hA5A5, 1'b0);
    collect(0); collect(1);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (err_cnt[d] !== exp_cnt) begin
        fails++; $display("FAIL b2b_errcnt dut%0d: %h, want %h", d, err_cnt[d], exp_cnt);
      end
    end
  endtask

  task automatic test_reset_inflight;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, 8'h00, 7'h09, 64'h0, 64'h1, 1'b1);
      if (k == 1) tick;  // now in WAIT
      rst = 1'b1;
      tick;
      rst = 1'b0;
      sb0.delete(); sb1.delete();
      exp_cnt = '0;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if ({csel[d], rsp_valid[d], req_ready[d], err_cnt[d]} !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
          fails++;
          $display("FAIL rst_inflight%0d dut%0d: csel=%b vld=%b ready=%b cnt=%h, want 0 0 1 0",
                   k, d, csel[d], rsp_valid[d], req_ready[d], err_cnt[d]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++;
      if (rsp_valid[0] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
        fails++;
        $display("FAIL rst_no_rsp: rsp_valid=%b/%b, want 0/0", rsp_valid[0], rsp_valid[1]);
      end
    end
  endtask

  task automatic test_saturate;
    force g_dut[0].u_dut.err_cnt_q = 16'hFFFE;
    force g_dut[1].u_dut.err_cnt_q = 16'hFFFE;
    tick;
    release g_dut[0].u_dut.err_cnt_q;
    release g_dut[1].u_dut.err_cnt_q;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (err_cnt[0] !== exp_cnt || err_cnt[1] !== exp_cnt) begin
        fails++;
        $display("FAIL saturate step%0d: cnt=%h/%h, want %h", k, err_cnt[0], err_cnt[1], exp_cnt);
      end
      if (k < 2) begin
        issue(1'b0, 8'h00, 7'h09, 64'h0, 64'h1, 1'b1);
        collect(0); collect(1);
        exp_cnt = 16'hFFFF;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      m1[i] = 64'(i);
      m2[i] = 64'(i);
    end
    m1[5]  = 64'hA5A5;             m2[5]  = 64'hA5A5;
    m1[9]  = 64'h1;                m2[9]  = 64'h3;
    m1[12] = 64'hCAFEF00D12345678; m2[12] = 64'hCAFEF00D12345678;
    csel_cnt[0] = 0; csel_cnt[1] = 0;
    test_reset;
    test_write;
    test_read;
    test_mismatch;
    test_backpressure;
    test_back_to_back;
    test_reset_inflight;
    test_saturate;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_requester.md
CACHE_REQUESTER -- requirements
Module: cache_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7: SRAM word address width.
REQ-002 SHALL have parameter OUT_REGS, default 0: SRAM output-register stages; read latency = 1+OUT_REGS cycles after CSel cycle.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Clk_CI  in  1  sole clock, rising edge.
REQ-005 Rst_RI  in  1  synchronous active-high reset.
REQ-006 ReqValid_SI in 1 / ReqReady_SO out 1: request handshake.
REQ-007 ReqWrEn_SI in 1, ReqBEn_SI in 8, ReqAddr_DI in ADDR_WIDTH, ReqWrData_DI in 64: request fields.
REQ-008 RspValid_SO out 1 / RspReady_SI in 1: response handshake.
REQ-009 RspData_DO out 64: read data (copy 1); RspErr_SO out 1: copy mismatch flag.
REQ-010 ErrCnt_DO out 16: saturating mismatch count.
REQ-011 CSel_SO, WrEn_SO out 1; BEn_SO out 8; WrData_DO out 64; Addr_DO out ADDR_WIDTH: to duplicated SRAM pair.
REQ-012 RdData_DI_1, RdData_DI_2 in 64: read data from copy 1 and copy 2.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, SCRUB, RESP.
REQ-014 IDLE: ReqReady_SO=1; on ReqValid_SI&ReqReady_SO latch all request fields, go ISSUE; ReqReady_SO=0 in every other state.
REQ-015 ISSUE (exactly 1 cycle): CSel_SO=1, WrEn_SO/BEn_SO/WrData_DO/Addr_DO = latched fields; write -> RESP, read -> WAIT.
REQ-016 WAIT: counts OUT_REGS+1 cycles after ISSUE, then on the 1+OUT_REGS-th cycle after ISSUE samples both RdData inputs.
REQ-017 On sample: RspData_DO <= RdData_DI_1; RspErr_SO <= (RdData_DI_1 != RdData_DI_2), full 64-bit compare.
REQ-018 On sampled mismatch ErrCnt_DO SHALL increment by 1, saturating at 16'hFFFF.
REQ-019 Write response: RspData_DO=0, RspErr_SO=0, ErrCnt unchanged.
REQ-020 RESP: RspValid_SO=1; RspData_DO/RspErr_SO stable until RspValid_SO&RspReady_SI, then IDLE.
REQ-021 Earliest back-to-back: new request accepted the cycle after response handshake (IDLE re-entry); no pipelining.
REQ-022 Outside ISSUE/SCRUB: CSel_SO=0, WrEn_SO=0, BEn_SO=0, WrData_DO=0, Addr_DO=0.
REQ-023 RdData inputs SHALL be ignored except at the sample cycle.
REQ-024 Request field changes while not in IDLE SHALL have no effect.

Reset
REQ-025 Rst_RI high at a rising edge SHALL force IDLE, abandoning any in-flight request, from any state.
REQ-026 After reset: ReqReady_SO=1, RspValid_SO=0, RspData_DO=0, RspErr_SO=0, ErrCnt_DO=0, all SRAM outputs 0.
REQ-027 Reset asserted in ISSUE or SCRUB SHALL deassert CSel_SO in the following cycle; no response emitted.

Configuration
REQ-028 Macro CACHE_REQUESTER_SCRUB_EN SHALL enable scrub-on-mismatch.
REQ-029 Defined: after a mismatched read, enter SCRUB for 1 cycle: CSel_SO=1, WrEn_SO=1, BEn_SO=8'hFF, WrData_DO=sampled RdData_DI_1, Addr_DO=latched address; then RESP with RspErr_SO=1.
REQ-030 Undefined: SCRUB unreachable, mismatched read goes directly to RESP; SRAM outputs never written on reads.

Verification
REQ-031 Write addr 7'h05, BEn 8'h0F, data 64'h1122334455667788 -> one CSel cycle with WrEn=1, those fields; RspValid with RspData=0, RspErr=0.
REQ-032 Read addr 7'h05, OUT_REGS=0 and 1, both copies 64'hA5A5 -> sample 1/2 cycles after ISSUE; RspData=64'hA5A5, RspErr=0, ErrCnt=0.
REQ-033 Read with copy1=64'h1, copy2=64'h3 -> RspErr=1, ErrCnt=1; with SCRUB_EN, one write cycle BEn=8'hFF data 64'h1 addr latched precedes RspValid.
REQ-034 Hold RspReady_SI=0 for 5 cycles in RESP -> RspValid, RspData, ReqReady=0 stable; no second CSel.
REQ-035 Rst_RI asserted in ISSUE and in WAIT -> next cycle IDLE, CSel=0, RspValid=0, ErrCnt=0.
REQ-036 Force ErrCnt to 16'hFFFF via mismatches -> further mismatch keeps 16'hFFFF.
